// File: rtl/fifo_sync_ctrl_pkg.sv
// fifo_sync_ctrl_pkg
//   Constants and a width helper shared by the synchronous FIFO files.
//   OUT_FWFT / OUT_REG : legal values of the REG_OUT parameter.
//   addr_width()       : bits needed to encode 0..n-1, never less than 1.
package fifo_sync_ctrl_pkg;

   localparam int OUT_FWFT = 0;
   localparam int OUT_REG  = 1;

   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   DEPTH x WIDTH storage: one synchronous write port, one asynchronous
//   read port. Contents are deliberately not reset.
//   clk        : write clock
//   write_en   : store write_data at write_addr on the rising edge
//   write_addr : write location
//   write_data : word to store
//   read_addr  : read location
//   read_data  : mem[read_addr], combinational
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             write_en,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (write_en) mem[write_addr] <= write_data;
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
//   Single-clock FIFO controller: pointers, fill level, threshold flags,
//   sticky error flags and the optional registered output stage.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   clear        : synchronous flush, overrides read/write
//   write        : push request, write_data is the word
//   read         : pop request
//   read_data    : head word (REG_OUT=0) or last popped word (REG_OUT=1)
//   read_valid   : REG_OUT=1 pop strobe, constant 0 otherwise
//   full / empty / almost_full / almost_empty : decoded from level
//   level        : entry count 0..DEPTH
//   overflow / underflow : sticky, set by a rejected write / read
module fifo_sync_ctrl
   import fifo_sync_ctrl_pkg::*;
#(
   parameter  int WIDTH        = 8,
   parameter  int DEPTH        = 16,
   parameter  int AFULL_LEVEL  = DEPTH - 2,
   parameter  int AEMPTY_LEVEL = 2,
   parameter  int REG_OUT      = 0,
   localparam int LW           = addr_width(DEPTH + 1),
   localparam int PW           = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             write,
   input  logic [WIDTH-1:0] write_data,
   input  logic             read,
   output logic [WIDTH-1:0] read_data,
   output logic             read_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [LW-1:0]    level,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    level_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             rd_acc;
   logic             wr_acc;
   logic [WIDTH-1:0] mem_rdata;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);

   // A pop frees a slot in the same edge, so a full FIFO still takes a
   // write alongside a read. An empty FIFO never bypasses write to read.
   assign rd_acc = read & ~empty;
   assign wr_acc = write & (~full | rd_acc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
         if (wr_acc && !rd_acc)      level_q <= level_q + 1'b1;
         else if (rd_acc && !wr_acc) level_q <= level_q - 1'b1;
         if (write && !wr_acc) overflow_q  <= 1'b1;
         if (read && !rd_acc)  underflow_q <= 1'b1;
      end
   end

   assign level        = level_q;
   assign almost_full  = (32'(level_q) >= AFULL_LEVEL);
   assign almost_empty = (32'(level_q) <= AEMPTY_LEVEL);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk        (clk),
      .write_en   (wr_acc & ~clear),
      .write_addr (wr_ptr),
      .write_data (write_data),
      .read_addr  (rd_ptr),
      .read_data  (mem_rdata)
   );

   if (REG_OUT == OUT_REG) begin : g_reg_out
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else if (clear) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem_rdata;
         end
      end

      assign read_data  = rdata_q;
      assign read_valid = rvalid_q;
   end else begin : g_fwft
      assign read_data  = mem_rdata;
      assign read_valid = 1'b0;
   end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl
//   Three instances: A (16 deep, fall-through), B (5 deep, fall-through,
//   pointer wrap) and C (8 deep, registered output). A queue per instance
//   holds the words the bench expects to come out.
module tb_fifo_sync_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- instance A ----------------
   logic       a_clear, a_write, a_read;
   logic [7:0] a_wdata, a_rdata;
   logic       a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
   logic [4:0] a_level;
   logic [7:0] sb_a[$];
   int         lvl_a;
   bit         ovf_a, udf_a;

   fifo_sync_ctrl #(.WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2), .REG_OUT(0)) dut_a (
      .clk(clk), .reset(reset), .clear(a_clear), .write(a_write), .write_data(a_wdata),
      .read(a_read), .read_data(a_rdata), .read_valid(a_rvalid), .full(a_full),
      .empty(a_empty), .almost_full(a_afull), .almost_empty(a_aempty), .level(a_level),
      .overflow(a_ovf), .underflow(a_udf));

   // ---------------- instance B ----------------
   logic       b_clear, b_write, b_read;
   logic [7:0] b_wdata, b_rdata;
   logic       b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
   logic [2:0] b_level;
   logic [7:0] sb_b[$];
   int         lvl_b;

   fifo_sync_ctrl #(.WIDTH(8), .DEPTH(5), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .REG_OUT(0)) dut_b (
      .clk(clk), .reset(reset), .clear(b_clear), .write(b_write), .write_data(b_wdata),
      .read(b_read), .read_data(b_rdata), .read_valid(b_rvalid), .full(b_full),
      .empty(b_empty), .almost_full(b_afull), .almost_empty(b_aempty), .level(b_level),
      .overflow(b_ovf), .underflow(b_udf));

   // ---------------- instance C ----------------
   logic       c_clear, c_write, c_read;
   logic [7:0] c_wdata, c_rdata;
   logic       c_rvalid, c_full, c_empty, c_afull, c_aempty, c_ovf, c_udf;
   logic [3:0] c_level;
   logic [7:0] sb_c[$];
   int         lvl_c;

   fifo_sync_ctrl #(.WIDTH(8), .DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2), .REG_OUT(1)) dut_c (
      .clk(clk), .reset(reset), .clear(c_clear), .write(c_write), .write_data(c_wdata),
      .read(c_read), .read_data(c_rdata), .read_valid(c_rvalid), .full(c_full),
      .empty(c_empty), .almost_full(c_afull), .almost_empty(c_aempty), .level(c_level),
      .overflow(c_ovf), .underflow(c_udf));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle on A; head word is sampled before the edge.
   task automatic a_cycle(input logic w, input logic [7:0] d, input logic r,
                          output logic popped, output logic [7:0] got, output logic [7:0] exp);
      bit rd, wr;
      a_write = w; a_wdata = d; a_read = r;
      #1;
      rd = r && (lvl_a > 0);
      wr = w && ((lvl_a < 16) || rd);
      popped = rd;
      got    = a_rdata;
      exp    = 8'h00;
      if (rd) exp = sb_a.pop_front();
      if (wr) sb_a.push_back(d);
      if (w && !wr) ovf_a = 1'b1;
      if (r && !rd) udf_a = 1'b1;
      lvl_a = lvl_a + int'(wr) - int'(rd);
      tick();
      a_write = 1'b0; a_read = 1'b0;
   endtask

   task automatic a_flush();
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      sb_a.delete(); lvl_a = 0; ovf_a = 1'b0; udf_a = 1'b0;
   endtask

   task automatic b_cycle(input logic w, input logic [7:0] d, input logic r,
                          output logic popped, output logic [7:0] got, output logic [7:0] exp);
      bit rd, wr;
      b_write = w; b_wdata = d; b_read = r;
      #1;
      rd = r && (lvl_b > 0);
      wr = w && ((lvl_b < 5) || rd);
      popped = rd;
      got    = b_rdata;
      exp    = 8'h00;
      if (rd) exp = sb_b.pop_front();
      if (wr) sb_b.push_back(d);
      lvl_b = lvl_b + int'(wr) - int'(rd);
      tick();
      b_write = 1'b0; b_read = 1'b0;
   endtask

   // Registered-output instance: result is visible after the edge.
   task automatic c_cycle(input logic w, input logic [7:0] d, input logic r,
                          output logic popped, output logic [7:0] exp);
      bit rd, wr;
      c_write = w; c_wdata = d; c_read = r;
      rd = r && (lvl_c > 0);
      wr = w && ((lvl_c < 8) || rd);
      popped = rd;
      exp    = 8'h00;
      if (rd) exp = sb_c.pop_front();
      if (wr) sb_c.push_back(d);
      lvl_c = lvl_c + int'(wr) - int'(rd);
      tick();
      c_write = 1'b0; c_read = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      n_vec++; if (a_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", a_level); end
      n_vec++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full: got %b%b want 10", a_empty, a_full); end
      n_vec++; if (a_aempty !== 1'b1 || a_afull !== 1'b0) begin n_err++; $display("FAIL reset_almost: got ae=%b af=%b want ae=1 af=0", a_aempty, a_afull); end
      n_vec++; if (a_ovf !== 1'b0 || a_udf !== 1'b0 || a_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ovf=%b udf=%b rv=%b want 000", a_ovf, a_udf, a_rvalid); end
      n_vec++; if (c_rdata !== 8'h00 || c_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_regout: got %h/%b want 00/0", c_rdata, c_rvalid); end
      tick(); tick();
      reset = 1'b1;
      tick();
      n_vec++; if (a_empty !== 1'b1 || a_level !== 5'd0) begin n_err++; $display("FAIL reset_release: got e=%b lvl=%0d want e=1 lvl=0", a_empty, a_level); end
   endtask

   task automatic test_fill_drain();
      logic p; logic [7:0] g, e;
      for (int i = 0; i < 15; i++) begin
         a_cycle(1'b1, 8'(8'h11 + i), 1'b0, p, g, e);
         n_vec++; if (a_level !== 5'(i + 1)) begin n_err++; $display("FAIL fill_level: got %0d want %0d", a_level, i + 1); end
         n_vec++; if (a_aempty !== ((i + 1) <= 2) || a_afull !== ((i + 1) >= 14)) begin
            n_err++; $display("FAIL fill_almost: lvl %0d got ae=%b af=%b", i + 1, a_aempty, a_afull); end
      end
      for (int i = 0; i < 15; i++) begin
         a_cycle(1'b0, 8'h00, 1'b1, p, g, e);
         n_vec++; if (p !== 1'b1 || g !== e) begin n_err++; $display("FAIL drain_data: got %h want %h", g, e); end
         n_vec++; if (a_level !== 5'(14 - i)) begin n_err++; $display("FAIL drain_level: got %0d want %0d", a_level, 14 - i); end
         n_vec++; if (a_aempty !== ((14 - i) <= 2) || a_afull !== ((14 - i) >= 14)) begin
            n_err++; $display("FAIL drain_almost: lvl %0d got ae=%b af=%b", 14 - i, a_aempty, a_afull); end
      end
      n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", a_empty); end
   endtask

   task automatic test_overflow();
      logic p; logic [7:0] g, e;
      for (int i = 0; i < 16; i++) a_cycle(1'b1, 8'(8'h20 + i), 1'b0, p, g, e);
      n_vec++; if (a_full !== 1'b1 || a_level !== 5'd16) begin n_err++; $display("FAIL ovf_fill: got full=%b lvl=%0d want 1/16", a_full, a_level); end
      n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_premature: got %b want 0", a_ovf); end
      a_cycle(1'b1, 8'hAA, 1'b0, p, g, e);
      n_vec++; if (a_ovf !== 1'b1 || a_full !== 1'b1 || a_level !== 5'd16) begin
         n_err++; $display("FAIL ovf_reject: got ovf=%b full=%b lvl=%0d want 1/1/16", a_ovf, a_full, a_level); end
      for (int i = 0; i < 16; i++) begin
         a_cycle(1'b0, 8'h00, 1'b1, p, g, e);
         n_vec++; if (g !== e) begin n_err++; $display("FAIL ovf_drain: got %h want %h", g, e); end
      end
      n_vec++; if (a_ovf !== 1'b1 || a_empty !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got ovf=%b e=%b want 1/1", a_ovf, a_empty); end
      a_flush();
      n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", a_ovf); end
   endtask

   task automatic test_full_rw();
      logic p; logic [7:0] g, e;
      for (int i = 0; i < 16; i++) a_cycle(1'b1, 8'(8'h30 + i), 1'b0, p, g, e);
      a_cycle(1'b1, 8'h55, 1'b1, p, g, e);
      n_vec++; if (g !== e) begin n_err++; $display("FAIL full_rw_head: got %h want %h", g, e); end
      n_vec++; if (a_level !== 5'd16 || a_full !== 1'b1 || a_ovf !== 1'b0) begin
         n_err++; $display("FAIL full_rw_state: got lvl=%0d full=%b ovf=%b want 16/1/0", a_level, a_full, a_ovf); end
      for (int i = 0; i < 16; i++) begin
         a_cycle(1'b0, 8'h00, 1'b1, p, g, e);
         n_vec++; if (g !== e) begin n_err++; $display("FAIL full_rw_drain: got %h want %h", g, e); end
      end
      n_vec++; if (g !== 8'h55) begin n_err++; $display("FAIL full_rw_last: got %h want 55", g); end
   endtask

   task automatic test_empty_rw();
      logic p; logic [7:0] g, e;
      a_cycle(1'b1, 8'h77, 1'b1, p, g, e);
      n_vec++; if (a_level !== 5'd1 || a_udf !== 1'b1 || a_ovf !== 1'b0) begin
         n_err++; $display("FAIL empty_rw_state: got lvl=%0d udf=%b ovf=%b want 1/1/0", a_level, a_udf, a_ovf); end
      a_cycle(1'b0, 8'h00, 1'b1, p, g, e);
      n_vec++; if (p !== 1'b1 || g !== e || g !== 8'h77) begin n_err++; $display("FAIL empty_rw_pop: got %h want 77", g); end
      n_vec++; if (a_empty !== 1'b1 || a_udf !== 1'b1) begin n_err++; $display("FAIL empty_rw_after: got e=%b udf=%b want 1/1", a_empty, a_udf); end
      a_flush();
   endtask

   task automatic test_back_to_back();
      logic p; logic [7:0] g, e;
      a_cycle(1'b1, 8'h80, 1'b0, p, g, e);
      for (int i = 0; i < 20; i++) begin
         a_cycle(1'b1, 8'($urandom), 1'b1, p, g, e);
         n_vec++; if (g !== e) begin n_err++; $display("FAIL b2b_data: got %h want %h", g, e); end
         n_vec++; if (a_level !== 5'd1) begin n_err++; $display("FAIL b2b_level: got %0d want 1", a_level); end
      end
      a_cycle(1'b0, 8'h00, 1'b1, p, g, e);
      n_vec++; if (g !== e) begin n_err++; $display("FAIL b2b_tail: got %h want %h", g, e); end
      n_vec++; if (a_ovf !== ovf_a || a_udf !== udf_a) begin n_err++; $display("FAIL b2b_flags: got %b%b want %b%b", a_ovf, a_udf, ovf_a, udf_a); end
   endtask

   task automatic test_wrap();
      logic p; logic [7:0] g, e;
      for (int i = 0; i < 3; i++) b_cycle(1'b1, 8'(8'h40 + i), 1'b0, p, g, e);
      for (int i = 0; i < 12; i++) begin
         b_cycle(1'b1, 8'(8'h50 + i), 1'b1, p, g, e);
         n_vec++; if (g !== e) begin n_err++; $display("FAIL wrap_data: got %h want %h", g, e); end
         n_vec++; if (b_level !== 3'd3) begin n_err++; $display("FAIL wrap_level: got %0d want 3", b_level); end
      end
      for (int i = 0; i < 2; i++) b_cycle(1'b1, 8'(8'h60 + i), 1'b0, p, g, e);
      n_vec++; if (b_full !== 1'b1 || b_afull !== 1'b1) begin n_err++; $display("FAIL wrap_full: got full=%b af=%b want 1/1", b_full, b_afull); end
      for (int i = 0; i < 5; i++) begin
         b_cycle(1'b0, 8'h00, 1'b1, p, g, e);
         n_vec++; if (g !== e) begin n_err++; $display("FAIL wrap_drain: got %h want %h", g, e); end
      end
      n_vec++; if (b_empty !== 1'b1 || b_aempty !== 1'b1 || b_ovf !== 1'b0 || b_udf !== 1'b0 || b_rvalid !== 1'b0) begin
         n_err++; $display("FAIL wrap_end: got e=%b ae=%b ovf=%b udf=%b rv=%b want 11000", b_empty, b_aempty, b_ovf, b_udf, b_rvalid); end
   endtask

   task automatic test_reg_out();
      logic p; logic [7:0] e, held;
      for (int i = 0; i < 4; i++) c_cycle(1'b1, 8'(8'hC0 + i), 1'b0, p, e);
      n_vec++; if (c_rvalid !== 1'b0 || c_level !== 4'd4) begin n_err++; $display("FAIL regout_push: got rv=%b lvl=%0d want 0/4", c_rvalid, c_level); end
      c_cycle(1'b0, 8'h00, 1'b1, p, e);
      n_vec++; if (c_rvalid !== 1'b1 || c_rdata !== e) begin n_err++; $display("FAIL regout_pop: got %h/%b want %h/1", c_rdata, c_rvalid, e); end
      held = e;
      c_cycle(1'b0, 8'h00, 1'b0, p, e);
      n_vec++; if (c_rvalid !== 1'b0 || c_rdata !== held) begin n_err++; $display("FAIL regout_hold: got %h/%b want %h/0", c_rdata, c_rvalid, held); end
      for (int i = 0; i < 3; i++) begin
         c_cycle(1'b0, 8'h00, 1'b1, p, e);
         n_vec++; if (c_rvalid !== 1'b1 || c_rdata !== e) begin n_err++; $display("FAIL regout_b2b: got %h/%b want %h/1", c_rdata, c_rvalid, e); end
         held = e;
      end
      c_cycle(1'b0, 8'h00, 1'b1, p, e);
      n_vec++; if (c_rvalid !== 1'b0 || c_rdata !== held || c_udf !== 1'b1) begin
         n_err++; $display("FAIL regout_empty_pop: got %h/%b udf=%b want %h/0 udf=1", c_rdata, c_rvalid, c_udf, held); end
   endtask

   task automatic test_clear();
      logic p; logic [7:0] e;
      for (int i = 0; i < 9; i++) c_cycle(1'b1, 8'(8'hD0 + i), 1'b0, p, e);
      n_vec++; if (c_full !== 1'b1 || c_afull !== 1'b1 || c_aempty !== 1'b0 || c_ovf !== 1'b1 || c_udf !== 1'b1) begin
         n_err++; $display("FAIL clear_pre: got full=%b af=%b ae=%b ovf=%b udf=%b want 1/1/0/1/1", c_full, c_afull, c_aempty, c_ovf, c_udf); end
      c_cycle(1'b0, 8'h00, 1'b1, p, e);
      c_clear = 1'b1; c_write = 1'b1; c_wdata = 8'hEE; c_read = 1'b1;
      tick();
      c_clear = 1'b0; c_write = 1'b0; c_read = 1'b0;
      sb_c.delete(); lvl_c = 0;
      n_vec++; if (c_level !== 4'd0 || c_empty !== 1'b1 || c_ovf !== 1'b0 || c_udf !== 1'b0) begin
         n_err++; $display("FAIL clear_state: got lvl=%0d e=%b ovf=%b udf=%b want 0/1/0/0", c_level, c_empty, c_ovf, c_udf); end
      n_vec++; if (c_rvalid !== 1'b0 || c_rdata !== 8'h00) begin n_err++; $display("FAIL clear_regout: got %h/%b want 00/0", c_rdata, c_rvalid); end
      c_cycle(1'b1, 8'hE1, 1'b0, p, e);
      c_cycle(1'b0, 8'h00, 1'b1, p, e);
      n_vec++; if (c_rdata !== e || e !== 8'hE1 || c_rvalid !== 1'b1) begin n_err++; $display("FAIL clear_reuse: got %h/%b want E1/1", c_rdata, c_rvalid); end
   endtask

   task automatic test_async_reset();
      logic p; logic [7:0] e;
      c_cycle(1'b1, 8'hF1, 1'b0, p, e);
      c_cycle(1'b1, 8'hF2, 1'b0, p, e);
      c_cycle(1'b0, 8'h00, 1'b1, p, e);
      n_vec++; if (c_rdata !== 8'hF1 || c_rvalid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %h/%b want F1/1", c_rdata, c_rvalid); end
      #2;
      reset = 1'b0;
      #1;
      n_vec++; if (c_rdata !== 8'h00 || c_rvalid !== 1'b0 || c_level !== 4'd0 || c_empty !== 1'b1) begin
         n_err++; $display("FAIL areset_now: got %h/%b lvl=%0d e=%b want 00/0/0/1", c_rdata, c_rvalid, c_level, c_empty); end
      sb_a.delete(); lvl_a = 0; sb_b.delete(); lvl_b = 0; sb_c.delete(); lvl_c = 0;
      tick();
      reset = 1'b1;
      tick();
      c_cycle(1'b1, 8'h99, 1'b0, p, e);
      c_cycle(1'b0, 8'h00, 1'b1, p, e);
      n_vec++; if (c_rdata !== 8'h99 || e !== 8'h99) begin n_err++; $display("FAIL areset_discard: got %h want 99", c_rdata); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      a_clear = 0; a_write = 0; a_read = 0; a_wdata = 0;
      b_clear = 0; b_write = 0; b_read = 0; b_wdata = 0;
      c_clear = 0; c_write = 0; c_read = 0; c_wdata = 0;
      lvl_a = 0; lvl_b = 0; lvl_c = 0; ovf_a = 0; udf_a = 0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_back_to_back();
      test_wrap();
      test_reg_out();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
